// File: rtl/nmea_uart_rx.sv
// 8N1 serial receiver for the GPS NMEA stream: 2-flop synchronizer, oversampled
// majority-vote bit sampling, start-glitch rejection and framing-error reporting.
module nmea_uart_rx #(
   parameter int SYSCLK_FREQ = 100_000_000,
   parameter int BAUD        = 9600,
   parameter int OVERSAMPLE  = 16
) (
   input  logic       sclk,
   input  logic       rstn,
   input  logic       rxd,
   output logic [7:0] dataByte,
   output logic       dataReady,
   output logic       frameErr,
   output logic       rxBusy
);

   localparam int TICK_DIV = (SYSCLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = $clog2(OVERSAMPLE);

   localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);
   // scnt values held while the 7th, 8th and 9th ticks of a bit arrive (defaults)
   localparam logic [SW-1:0] SMP_A = SW'(OVERSAMPLE / 2 - 2);
   localparam logic [SW-1:0] SMP_B = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SMP_C = SW'(OVERSAMPLE / 2);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [1:0]    sync_r;
   logic          rxs_s;
   logic [DW-1:0] div_r;
   logic          tick_s;
   logic          restart_s;
   state_t        state_r, state_nxt_s;
   logic [SW-1:0] scnt_r, scnt_nxt_s, scnt_inc_s;
   logic [2:0]    bcnt_r, bcnt_nxt_s;
   logic [7:0]    shreg_r, shreg_nxt_s;
   logic          v0_r, v0_nxt_s, v1_r, v1_nxt_s;
   logic          vote_s, vote_at_s, wrap_s;
   logic [7:0]    byte_r, byte_nxt_s;
   logic          ready_r, ready_nxt_s;
   logic          ferr_r, ferr_nxt_s;
   logic          busy_r, busy_nxt_s;

   assign rxs_s      = sync_r[1];
   assign tick_s     = (div_r == DIV_LAST);
   assign vote_s     = maj3(v0_r, v1_r, rxs_s);
   assign vote_at_s  = tick_s && (scnt_r == SMP_C);
   assign wrap_s     = tick_s && (scnt_r == SCNT_LAST);
   assign scnt_inc_s = (scnt_r == SCNT_LAST) ? {SW{1'b0}} : scnt_r + SW'(1);

   assign dataByte  = byte_r;
   assign dataReady = ready_r;
   assign frameErr  = ferr_r;
   assign rxBusy    = busy_r;

   // Two-flop synchronizer for the asynchronous serial line
   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], rxd};
      end
   end

   // Tick divider, re-phased to the detected start edge
   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         div_r <= {DW{1'b0}};
      end else if (restart_s || tick_s) begin
         div_r <= {DW{1'b0}};
      end else begin
         div_r <= div_r + DW'(1);
      end
   end

   // Next-state and next-output logic of the receive FSM
   always_comb begin
      state_nxt_s = state_r;
      scnt_nxt_s  = scnt_r;
      bcnt_nxt_s  = bcnt_r;
      shreg_nxt_s = shreg_r;
      byte_nxt_s  = byte_r;
      ready_nxt_s = 1'b0;
      ferr_nxt_s  = 1'b0;
      busy_nxt_s  = busy_r;
      restart_s   = 1'b0;
      v0_nxt_s    = (tick_s && (scnt_r == SMP_A)) ? rxs_s : v0_r;
      v1_nxt_s    = (tick_s && (scnt_r == SMP_B)) ? rxs_s : v1_r;
      case (state_r)
         IDLE: begin
            if (!rxs_s) begin
               state_nxt_s = START;
               scnt_nxt_s  = {SW{1'b0}};
               restart_s   = 1'b1;
               busy_nxt_s  = 1'b1;
            end else begin
               busy_nxt_s  = 1'b0;
            end
         end
         START: begin
            scnt_nxt_s = tick_s ? scnt_inc_s : scnt_r;
            if (vote_at_s && vote_s) begin
               state_nxt_s = IDLE;
               busy_nxt_s  = 1'b0;
            end else if (wrap_s) begin
               state_nxt_s = DATA;
               bcnt_nxt_s  = 3'd0;
            end else begin
               state_nxt_s = START;
            end
         end
         DATA: begin
            scnt_nxt_s  = tick_s ? scnt_inc_s : scnt_r;
            shreg_nxt_s = vote_at_s ? {vote_s, shreg_r[7:1]} : shreg_r;
            if (wrap_s) begin
               bcnt_nxt_s  = bcnt_r + 3'd1;
               state_nxt_s = (bcnt_r == 3'd7) ? STOP : DATA;
            end else begin
               bcnt_nxt_s  = bcnt_r;
            end
         end
         STOP: begin
            scnt_nxt_s = tick_s ? scnt_inc_s : scnt_r;
            if (vote_at_s && vote_s) begin
               byte_nxt_s  = shreg_r;
               ready_nxt_s = 1'b1;
               busy_nxt_s  = 1'b0;
               state_nxt_s = IDLE;
            end else if (vote_at_s) begin
               ferr_nxt_s  = 1'b1;
               scnt_nxt_s  = {SW{1'b0}};
               state_nxt_s = WAIT_IDLE;
            end else begin
               state_nxt_s = STOP;
            end
         end
         WAIT_IDLE: begin
            // scnt counts consecutive high ticks here
            if (tick_s && !rxs_s) begin
               scnt_nxt_s = {SW{1'b0}};
            end else if (tick_s && (scnt_r == SCNT_LAST)) begin
               scnt_nxt_s  = {SW{1'b0}};
               busy_nxt_s  = 1'b0;
               state_nxt_s = IDLE;
            end else if (tick_s) begin
               scnt_nxt_s = scnt_r + SW'(1);
            end else begin
               scnt_nxt_s = scnt_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   // FSM state, datapath and registered outputs
   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
         scnt_r  <= {SW{1'b0}};
         bcnt_r  <= 3'd0;
         shreg_r <= 8'd0;
         v0_r    <= 1'b1;
         v1_r    <= 1'b1;
         byte_r  <= 8'd0;
         ready_r <= 1'b0;
         ferr_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         scnt_r  <= scnt_nxt_s;
         bcnt_r  <= bcnt_nxt_s;
         shreg_r <= shreg_nxt_s;
         v0_r    <= v0_nxt_s;
         v1_r    <= v1_nxt_s;
         byte_r  <= byte_nxt_s;
         ready_r <= ready_nxt_s;
         ferr_r  <= ferr_nxt_s;
         busy_r  <= busy_nxt_s;
      end
   end

endmodule

// File: tb/tb_nmea_uart_rx.sv
// Directed self-checking bench for nmea_uart_rx, scaled to 2 sclk per tick
// (32 sclk = 320 ns per bit) so whole sentences stay short in simulation.
`timescale 1ns/1ps
module tb_nmea_uart_rx;

   localparam int  SYSCLK = 307_200;
   localparam real BT     = 320.0;

   logic       sclk = 1'b0;
   logic       rstn;
   logic       rxd;
   logic [7:0] dataByte;
   logic       dataReady;
   logic       frameErr;
   logic       rxBusy;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] rx_q[$];
   int         n_ready = 0, n_ferr = 0, n_overlap = 0, n_long = 0;
   logic       ready_d = 1'b0, ferr_d = 1'b0;
   realtime    t_start = 0.0, t_ready = 0.0;

   nmea_uart_rx #(.SYSCLK_FREQ(SYSCLK), .BAUD(9600), .OVERSAMPLE(16)) dut (
      .sclk(sclk), .rstn(rstn), .rxd(rxd),
      .dataByte(dataByte), .dataReady(dataReady), .frameErr(frameErr), .rxBusy(rxBusy)
   );

   always #5 sclk = ~sclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: records every pulse, and pulse overlap/width violations
   always @(negedge sclk) begin
      if (dataReady) begin
         n_ready <= n_ready + 1;
         rx_q.push_back(dataByte);
         t_ready <= $realtime;
      end
      if (frameErr) n_ferr <= n_ferr + 1;
      if (dataReady && frameErr) n_overlap <= n_overlap + 1;
      if ((dataReady && ready_d) || (frameErr && ferr_d)) n_long <= n_long + 1;
      ready_d <= dataReady;
      ferr_d  <= frameErr;
   end

   task automatic send_byte(input logic [7:0] b, input real bt, input logic stop);
      rxd = 1'b0;
      t_start = $realtime;
      #(bt);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         #(bt);
      end
      rxd = stop;
      #(bt);
   endtask

   task automatic check_queue(input string tag, input string s);
      logic [31:0] got;
      for (int i = 0; i < s.len(); i++) begin
         got = (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD;
         check($sformatf("%s_byte%0d", tag, i), got, {24'd0, s[i]});
      end
   endtask

   initial begin
      int         r0, f0;
      real        lat, bt;
      string      s;
      logic [7:0] b31;
      real        rates[2];
      rates[0] = 1.03;
      rates[1] = 0.97;

      rxd  = 1'b1;
      rstn = 1'b0;
      #20;
      check("rst_byte",  dataByte,  8'h00);
      check("rst_ready", dataReady, 1'b0);
      check("rst_ferr",  frameErr,  1'b0);
      check("rst_busy",  rxBusy,    1'b0);
      #20 rstn = 1'b1;
      #(2.0 * BT);

      // single '$' and its latency
      r0 = n_ready; f0 = n_ferr;
      send_byte(8'h24, BT, 1'b1);
      #(BT);
      lat = t_ready - t_start;
      check("t1_count", n_ready - r0, 1);
      check("t1_byte", dataByte, 8'h24);
      check("t1_ferr", n_ferr - f0, 0);
      check("t1_latency_window", (lat >= 3040.0) && (lat <= 3140.0), 1'b1);
      check("t1_busy_idle", rxBusy, 1'b0);

      // back-to-back bytes, no idle gap
      s = "$GPGGA,";
      rx_q.delete();
      r0 = n_ready; f0 = n_ferr;
      for (int i = 0; i < s.len(); i++) send_byte(s[i], BT, 1'b1);
      #(BT);
      check("t2_count", n_ready - r0, s.len());
      check("t2_ferr", n_ferr - f0, 0);
      check_queue("t2", s);

      // short start glitch
      r0 = n_ready; f0 = n_ferr;
      rxd = 1'b0;
      #40 rxd = 1'b1;
      #40;
      check("t3_busy_seen", rxBusy, 1'b1);
      #(BT);
      check("t3_busy_low", rxBusy, 1'b0);
      check("t3_ready", n_ready - r0, 0);
      check("t3_ferr", n_ferr - f0, 0);
      #(BT);

      // framing error then recovery
      r0 = n_ready; f0 = n_ferr;
      send_byte(8'h55, BT, 1'b0);
      #(BT);
      rxd = 1'b1;
      #(2.0 * BT);
      check("t4_ferr", n_ferr - f0, 1);
      check("t4_no_ready", n_ready - r0, 0);
      check("t4_byte_held", dataByte, 8'h2C);
      check("t4_busy_low", rxBusy, 1'b0);
      send_byte(8'h0D, BT, 1'b1);
      #(BT);
      check("t4_ready", n_ready - r0, 1);
      check("t4_byte", dataByte, 8'h0D);
      check("t4_ferr_after", n_ferr - f0, 1);

      // reset in the middle of bit 4 of 0x31
      r0 = n_ready; f0 = n_ferr;
      b31 = 8'h31;
      rxd = 1'b0;
      #(BT);
      for (int i = 0; i < 4; i++) begin
         rxd = b31[i];
         #(BT);
      end
      rxd = b31[4];
      #(BT / 2.0);
      rstn = 1'b0;
      rxd  = 1'b1;
      #30;
      check("t5_rst_byte",  dataByte,  8'h00);
      check("t5_rst_ready", dataReady, 1'b0);
      check("t5_rst_ferr",  frameErr,  1'b0);
      check("t5_rst_busy",  rxBusy,    1'b0);
      #(BT - 30.0);
      rstn = 1'b1;
      #(2.0 * BT);
      send_byte(8'h0A, BT, 1'b1);
      #(BT);
      check("t5_ready", n_ready - r0, 1);
      check("t5_byte", dataByte, 8'h0A);
      check("t5_ferr", n_ferr - f0, 0);

      // full sentence at +3% and -3% sender rate
      s = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\r\n";
      for (int k = 0; k < 2; k++) begin
         bt = BT / rates[k];
         rx_q.delete();
         r0 = n_ready; f0 = n_ferr;
         for (int i = 0; i < s.len(); i++) send_byte(s[i], bt, 1'b1);
         #(2.0 * bt);
         check($sformatf("t6_count_r%0d", k), n_ready - r0, s.len());
         check($sformatf("t6_ferr_r%0d", k), n_ferr - f0, 0);
         check_queue($sformatf("t6_r%0d", k), s);
      end

      check("pulse_overlap", n_overlap, 0);
      check("pulse_width", n_long, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
